// File: rtl/serial_addsub_ctrl.sv
// Nibble-serial add/subtract sequencer: one 4-bit adder slice is reused over WIDTH/4 cycles,
// LSB nibble first, with a registered carry. Valid/ready start, one-cycle done pulse.
module serial_addsub_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf,
  output logic             done,
  output logic             busy
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [NIB-1:0][3:0] a_q, a_d;
  logic [NIB-1:0][3:0] b_q, b_d;
  logic [NIB-1:0][3:0] res_q, res_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                carry_q, carry_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;
  logic [4:0]          slice;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // The shared 4-bit slice; B is stored pre-inverted for subtract, carry-in seeded with sub.
  assign slice = {1'b0, a_q[idx_q]} + {1'b0, b_q[idx_q]} + {4'b0000, carry_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        res_d[idx_q] = slice[3:0];
        carry_d      = slice[4];
        idx_d        = idx_q + IdxW'(1);
        if (idx_q == IdxW'(NIB - 1)) begin
          cout_d  = slice[4];
          // slice[3] is the final result MSB written on this edge
          ovf_d   = (a_q[NIB-1][3] == b_q[NIB-1][3]) && (slice[3] != a_q[NIB-1][3]);
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign start_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign res         = res_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: vector table on a 16-bit instance, hand sequences
// for back-to-back accepts, mid-operation reset and the single-nibble configuration.
module tb_serial_addsub_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sv = 1'b0, sr;
  logic [15:0] a = '0, b = '0, res;
  logic        sub = 1'b0, cout, ovf, done, busy;

  logic        sv4 = 1'b0, sr4;
  logic [3:0]  a4 = '0, b4 = '0, res4;
  logic        sub4 = 1'b0, cout4, ovf4, done4, busy4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_addsub_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start_valid(sv), .start_ready(sr), .a(a), .b(b), .sub(sub),
    .res(res), .cout(cout), .ovf(ovf), .done(done), .busy(busy)
  );

  serial_addsub_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start_valid(sv4), .start_ready(sr4), .a(a4), .b(b4), .sub(sub4),
    .res(res4), .cout(cout4), .ovf(ovf4), .done(done4), .busy(busy4)
  );

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vsub;
    logic [15:0] eres;
    logic        ecout;
    logic        eovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // One full transaction with latency, handshake and hold checks.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                       input logic [15:0] eres, input logic ecout, input logic eovf);
    int lat;
    logic [15:0] held;
    @(negedge clk);
    a = ta; b = tb; sub = ts; sv = 1'b1;
    check("ready_in_idle", {31'b0, sr}, 32'd1);
    @(posedge clk); #1;
    sv = 1'b0; a = ~ta; b = ~tb; sub = ~ts;  // post-accept changes must be ignored
    check("ready_low_run", {31'b0, sr}, 32'd0);
    check("busy_run", {31'b0, busy}, 32'd1);
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    check("latency", lat, 32'd4);
    check("ready_low_done", {31'b0, sr}, 32'd0);
    check("res", {16'b0, res}, {16'b0, eres});
    check("cout", {31'b0, cout}, {31'b0, ecout});
    check("ovf", {31'b0, ovf}, {31'b0, eovf});
    held = res;
    @(posedge clk); #1;
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("ready_after", {31'b0, sr}, 32'd1);
    check("busy_after", {31'b0, busy}, 32'd0);
    check("res_held", {16'b0, res}, {16'b0, held});
  endtask

  initial begin
    logic [16:0] q[$];
    logic [16:0] exp;
    int prev_done, n_done, n_acc;

    vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
    vecs[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[2] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'hA5A5, 16'hA5A5, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

    #12;
    check("rst_res", {16'b0, res}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_cout_ovf", {30'b0, cout, ovf}, 32'd0);
    @(negedge clk); rst = 1'b0;
    #1 check("ready_after_rst", {31'b0, sr}, 32'd1);

    foreach (vecs[i]) do_op(vecs[i].va, vecs[i].vb, vecs[i].vsub,
                            vecs[i].eres, vecs[i].ecout, vecs[i].eovf);

    // start_valid held high, operands changing every cycle
    prev_done = -1; n_done = 0; n_acc = 0;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      a = 16'h0101 * c[15:0] + 16'h0040;
      b = 16'h1003 * c[15:0] + 16'hF000;
      sub = 1'b0; sv = 1'b1;
      if (sr) begin
        q.push_back({1'b0, a} + {1'b0, b});
        n_acc++;
      end
      @(posedge clk); #1;
      if (done) begin
        exp = q.pop_front();
        check("b2b_res", {16'b0, res}, {16'b0, exp[15:0]});
        check("b2b_cout", {31'b0, cout}, {31'b0, exp[16]});
        if (prev_done >= 0) check("b2b_period", c - prev_done, 32'd6);
        prev_done = c;
        n_done++;
      end
    end
    sv = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) begin
        exp = q.pop_front();
        check("b2b_res_tail", {16'b0, res}, {16'b0, exp[15:0]});
        n_done++;
      end
    end
    check("b2b_accepts", n_acc, 32'd4);
    check("b2b_dones", n_done, n_acc);

    // asynchronous reset at idx=2 mid-operation
    do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; sv = 1'b1;
    @(posedge clk); #1 sv = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_res", {16'b0, res}, 32'd0);
    check("arst_cout_ovf", {30'b0, cout, ovf}, 32'd0);
    check("arst_busy_done", {30'b0, busy, done}, 32'd0);
    @(posedge clk); #3 rst = 1'b0;
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("no_done_after_rst", n_done, 32'd0);
    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // WIDTH=4 instance
    @(negedge clk);
    a4 = 4'h9; b4 = 4'h9; sub4 = 1'b0; sv4 = 1'b1;
    @(posedge clk); #1 sv4 = 1'b0;
    check("w4_not_done_run", {31'b0, done4}, 32'd0);
    @(posedge clk); #1;
    check("w4_done", {31'b0, done4}, 32'd1);
    check("w4_res", {28'b0, res4}, 32'h2);
    check("w4_cout_ovf", {30'b0, cout4, ovf4}, 32'd3);
    @(posedge clk); #1;
    check("w4_done_pulse", {31'b0, done4}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
